mem_loader: RTL and testbench

Program loader that writes a byte stream into the 32-bit word RAM behind the CPU's instruction fetch path. The CPU only reads memory; this block is the write side of the same word-addressed interface. It accepts bytes over a valid/ready handshake, packs them big-endian into 32-bit words, and issues one single-cycle write per word at consecutive addresses from 0. It reports completion and the number of words written.

---
 rtl/mem_loader.sv | 159 +++++++++++++++
 tb/tb_mem_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// mem_loader: write side of the CPU instruction RAM. Accepts a byte stream over a
// valid/ready handshake, packs bytes big-endian into 32-bit words and issues one
// single-cycle write per word at consecutive word addresses starting from 0.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               restart pulse, honoured only while done
//   in_valid/in_ready   byte handshake; in_data is the byte, in_last marks the final byte
//   wr_en/wr_addr/wr_data  registered RAM write port (one-cycle strobe per word)
//   done                loading finished (last byte written or RAM full)
//   full                sticky: the top word address has been written
//   word_count          words written since reset or the last start
module mem_loader #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              done,
    output logic              full,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [1:0] StCollect = 2'd0;
    localparam logic [1:0] StWrite   = 2'd1;
    localparam logic [1:0] StDone    = 2'd2;

    localparam logic [ADDR_W-1:0] AddrMax = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CntOne  = (ADDR_W + 1)'(1);

    logic [1:0]        state_q, state_d;
    logic [23:0]       shift_q, shift_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              full_q, full_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;

    logic              accept;
    logic [31:0]       packed_word;

    assign accept = in_valid && (state_q == StCollect);

    // Word formed by the bytes held so far plus the incoming one; unused low
    // bytes are zero so a partial final word is padded.
    always_comb begin
        packed_word = 32'h0;
        case (byte_cnt_q)
            2'd0:    packed_word = {in_data, 24'h0};
            2'd1:    packed_word = {shift_q[7:0], in_data, 16'h0};
            2'd2:    packed_word = {shift_q[15:0], in_data, 8'h0};
            default: packed_word = {shift_q[23:0], in_data};
        endcase
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        last_d       = last_q;
        addr_d       = addr_q;
        wr_en_d      = wr_en_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        full_d       = full_q;
        word_count_d = word_count_q;

        case (state_q)
            StCollect: begin
                if (accept) begin
                    shift_d    = {shift_q[15:0], in_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3 || in_last) begin
                        state_d    = StWrite;
                        wr_en_d    = 1'b1;
                        wr_data_d  = packed_word;
                        wr_addr_d  = addr_q;
                        byte_cnt_d = 2'd0;
                        last_d     = in_last;
                    end
                end
            end
            StWrite: begin
                wr_en_d      = 1'b0;
                word_count_d = word_count_q + CntOne;
                addr_d       = addr_q + AddrOne;
                // Top slot written: stop rather than wrap onto address 0.
                if (addr_q == AddrMax) begin
                    full_d = 1'b1;
                end
                if (last_q || addr_q == AddrMax) begin
                    state_d = StDone;
                end else begin
                    state_d = StCollect;
                end
            end
            StDone: begin
                if (start) begin
                    state_d      = StCollect;
                    addr_d       = '0;
                    byte_cnt_d   = 2'd0;
                    shift_d      = 24'h0;
                    last_d       = 1'b0;
                    word_count_d = '0;
                    full_d       = 1'b0;
                end
            end
            default: begin
                state_d = StCollect;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StCollect;
            shift_q      <= 24'h0;
            byte_cnt_q   <= 2'd0;
            last_q       <= 1'b0;
            addr_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 32'h0;
            full_q       <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            last_q       <= last_d;
            addr_q       <= addr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            full_q       <= full_d;
            word_count_q <= word_count_d;
        end
    end

    assign in_ready   = (state_q == StCollect);
    assign done       = (state_q == StDone);
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign full       = full_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: a default-size instance (ADDR_W=6) and a small one
// (ADDR_W=2) share all inputs; the small one is only examined in the overflow test.
module tb_mem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;

    logic        in_ready6, wr_en6, done6, full6;
    logic [5:0]  wr_addr6;
    logic [31:0] wr_data6;
    logic [6:0]  word_count6;

    logic        in_ready2, wr_en2, done2, full2;
    logic [1:0]  wr_addr2;
    logic [31:0] wr_data2;
    logic [2:0]  word_count2;

    int n_chk;
    int n_fail;

    // RAM-side view of every write: captured on the edge where wr_en is high.
    logic [5:0]  wa6[$];
    logic [31:0] wd6[$];
    logic [1:0]  wa2[$];
    logic [31:0] wd2[$];

    bit mon_en;
    int nr_cnt;

    mem_loader #(.ADDR_W(6)) u_dut6 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready6), .wr_en(wr_en6), .wr_addr(wr_addr6),
        .wr_data(wr_data6), .done(done6), .full(full6), .word_count(word_count6)
    );

    mem_loader #(.ADDR_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready2), .wr_en(wr_en2), .wr_addr(wr_addr2),
        .wr_data(wr_data2), .done(done2), .full(full2), .word_count(word_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en6) begin
            wa6.push_back(wr_addr6);
            wd6.push_back(wr_data6);
        end
        if (wr_en2) begin
            wa2.push_back(wr_addr2);
            wd2.push_back(wr_data2);
        end
    end

    always @(negedge clk) begin
        if (mon_en && !done6 && !in_ready6) nr_cnt++;
    end

    task automatic clear_log();
        wa6.delete(); wd6.delete(); wa2.delete(); wd2.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        clear_log();
        rst = 1'b0;
    endtask

    // Offers one byte (to the default instance) and returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input logic last);
        bit ok;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready6) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (ok) begin
            @(posedge clk); #1;
        end else begin
            n_chk++; n_fail++;
            $display("FAIL send_byte_timeout byte %h in_ready got 0 exp 1", b);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 50; i++) begin
            if (done6) break;
            @(posedge clk); #1;
        end
        n_chk++;
        if (done6 !== 1'b1) begin
            n_fail++; $display("FAIL wait_done got %0b exp 1", done6);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (in_ready6 !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %0b exp 1", in_ready6); end
        n_chk++; if (wr_en6 !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en got %0b exp 0", wr_en6); end
        n_chk++; if (wr_addr6 !== 6'd0) begin n_fail++; $display("FAIL rst_wr_addr got %0d exp 0", wr_addr6); end
        n_chk++; if (wr_data6 !== 32'h0) begin n_fail++; $display("FAIL rst_wr_data got %h exp 0", wr_data6); end
        n_chk++; if (done6 !== 1'b0) begin n_fail++; $display("FAIL rst_done got %0b exp 0", done6); end
        n_chk++; if (full6 !== 1'b0) begin n_fail++; $display("FAIL rst_full got %0b exp 0", full6); end
        n_chk++; if (word_count6 !== 7'd0) begin n_fail++; $display("FAIL rst_word_count got %0d exp 0", word_count6); end
        do_reset();
    endtask

    task automatic test_full_word();
        do_reset();
        send_byte(8'hE3, 1'b0);
        send_byte(8'hA0, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b1);
        n_chk++; if (wr_en6 !== 1'b1) begin n_fail++; $display("FAIL fw_wr_en_rise got %0b exp 1", wr_en6); end
        n_chk++; if (in_ready6 !== 1'b0) begin n_fail++; $display("FAIL fw_ready_in_write got %0b exp 0", in_ready6); end
        @(posedge clk); #1;
        n_chk++; if (wr_en6 !== 1'b0) begin n_fail++; $display("FAIL fw_wr_en_fall got %0b exp 0", wr_en6); end
        n_chk++; if (done6 !== 1'b1) begin n_fail++; $display("FAIL fw_done got %0b exp 1", done6); end
        n_chk++; if (word_count6 !== 7'd1) begin n_fail++; $display("FAIL fw_word_count got %0d exp 1", word_count6); end
        n_chk++; if (full6 !== 1'b0) begin n_fail++; $display("FAIL fw_full got %0b exp 0", full6); end
        n_chk++; if (wa6.size() !== 1) begin n_fail++; $display("FAIL fw_nwrites got %0d exp 1", wa6.size()); end
        n_chk++; if (wa6[0] !== 6'd0 || wd6[0] !== 32'hE3A00001) begin n_fail++; $display("FAIL fw_write got %0d:%h exp 0:e3a00001", wa6[0], wd6[0]); end
    endtask

    task automatic test_stall_gap();
        do_reset();
        nr_cnt = 0;
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(8'(i), 1'b0);
        idle(3);
        for (int i = 3; i < 8; i++) send_byte(8'(i), i == 7);
        wait_done();
        mon_en = 1'b0;
        n_chk++; if (wa6.size() !== 2) begin n_fail++; $display("FAIL sg_nwrites got %0d exp 2", wa6.size()); end
        n_chk++; if (wa6[0] !== 6'd0 || wd6[0] !== 32'h00010203) begin n_fail++; $display("FAIL sg_write0 got %0d:%h exp 0:00010203", wa6[0], wd6[0]); end
        n_chk++; if (wa6[1] !== 6'd1 || wd6[1] !== 32'h04050607) begin n_fail++; $display("FAIL sg_write1 got %0d:%h exp 1:04050607", wa6[1], wd6[1]); end
        n_chk++; if (nr_cnt !== 2) begin n_fail++; $display("FAIL sg_not_ready_cycles got %0d exp 2", nr_cnt); end
        n_chk++; if (word_count6 !== 7'd2) begin n_fail++; $display("FAIL sg_word_count got %0d exp 2", word_count6); end
    endtask

    task automatic test_partial();
        do_reset();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b1);
        wait_done();
        n_chk++; if (wa6.size() !== 1) begin n_fail++; $display("FAIL pw_nwrites got %0d exp 1", wa6.size()); end
        n_chk++; if (wa6[0] !== 6'd0 || wd6[0] !== 32'hAABBCC00) begin n_fail++; $display("FAIL pw_write got %0d:%h exp 0:aabbcc00", wa6[0], wd6[0]); end
        n_chk++; if (word_count6 !== 7'd1) begin n_fail++; $display("FAIL pw_word_count got %0d exp 1", word_count6); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_ov[4];
        exp_ov = '{32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F};
        do_reset();
        for (int w = 0; w < 5; w++)
            for (int b = 0; b < 4; b++) send_byte(8'h10 + 8'(w * 4 + b), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (wa2.size() !== 4) begin n_fail++; $display("FAIL ov_nwrites got %0d exp 4", wa2.size()); end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (wa2[i] !== 2'(i) || wd2[i] !== exp_ov[i]) begin
                n_fail++; $display("FAIL ov_write%0d got %0d:%h exp %0d:%h", i, wa2[i], wd2[i], i, exp_ov[i]);
            end
        end
        n_chk++; if (full2 !== 1'b1) begin n_fail++; $display("FAIL ov_full got %0b exp 1", full2); end
        n_chk++; if (done2 !== 1'b1) begin n_fail++; $display("FAIL ov_done got %0b exp 1", done2); end
        n_chk++; if (in_ready2 !== 1'b0) begin n_fail++; $display("FAIL ov_in_ready got %0b exp 0", in_ready2); end
        n_chk++; if (word_count2 !== 3'd4) begin n_fail++; $display("FAIL ov_word_count got %0d exp 4", word_count2); end
        n_chk++; if (full6 !== 1'b0) begin n_fail++; $display("FAIL ov_big_full got %0b exp 0", full6); end
    endtask

    task automatic test_reset_mid();
        // Entered straight from overflow: wr_addr/wr_data/word_count are non-zero here.
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        clear_log();
        #2 rst = 1'b1;
        #1;
        n_chk++; if (wr_data6 !== 32'h0) begin n_fail++; $display("FAIL rm_wr_data got %h exp 0", wr_data6); end
        n_chk++; if (wr_addr6 !== 6'd0) begin n_fail++; $display("FAIL rm_wr_addr got %0d exp 0", wr_addr6); end
        n_chk++; if (word_count6 !== 7'd0) begin n_fail++; $display("FAIL rm_word_count got %0d exp 0", word_count6); end
        n_chk++; if (in_ready6 !== 1'b1 || done6 !== 1'b0 || full6 !== 1'b0) begin
            n_fail++; $display("FAIL rm_flags got rdy%0b done%0b full%0b exp 1 0 0", in_ready6, done6, full6);
        end
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        wait_done();
        n_chk++; if (wa6.size() !== 1) begin n_fail++; $display("FAIL rm_nwrites got %0d exp 1", wa6.size()); end
        n_chk++; if (wa6[0] !== 6'd0 || wd6[0] !== 32'h11223344) begin n_fail++; $display("FAIL rm_write got %0d:%h exp 0:11223344", wa6[0], wd6[0]); end
        // Reset landing in the write cycle must drop wr_en without a clock edge.
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'h70 + 8'(i), i == 3);
        #2 rst = 1'b1;
        #1;
        n_chk++; if (wr_en6 !== 1'b0) begin n_fail++; $display("FAIL rw_wr_en_async got %0b exp 0", wr_en6); end
        @(negedge clk);
        n_chk++; if (wa6.size() !== 0) begin n_fail++; $display("FAIL rw_nwrites got %0d exp 0", wa6.size()); end
        rst = 1'b0;
    endtask

    task automatic test_restart();
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'h80 + 8'(i), i == 3);
        wait_done();
        clear_log();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_chk++; if (done6 !== 1'b0) begin n_fail++; $display("FAIL rs_done_low got %0b exp 0", done6); end
        n_chk++; if (word_count6 !== 7'd0) begin n_fail++; $display("FAIL rs_word_count_clr got %0d exp 0", word_count6); end
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        // start while collecting must not disturb the partial word
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_byte(8'hBE, 1'b0);
        send_byte(8'hEF, 1'b1);
        wait_done();
        n_chk++; if (wa6.size() !== 1) begin n_fail++; $display("FAIL rs_nwrites got %0d exp 1", wa6.size()); end
        n_chk++; if (wa6[0] !== 6'd0 || wd6[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rs_write got %0d:%h exp 0:deadbeef", wa6[0], wd6[0]); end
        n_chk++; if (word_count6 !== 7'd1) begin n_fail++; $display("FAIL rs_word_count got %0d exp 1", word_count6); end
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        nr_cnt   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        test_reset();
        test_full_word();
        test_stall_gap();
        test_partial();
        test_overflow();
        test_reset_mid();
        test_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
